// File: rtl/status_pkt_receiver_pkg.sv
// Shared status channel definitions: word geometry, packet sizing
// and the FSM encoding common to transmitter and receiver.
package status_pkt_receiver_pkg;

   localparam int STATUS_BYTES_PER_WORD = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } status_state_e;

   function automatic int status_data_bytes(input int extra_words);
      return STATUS_BYTES_PER_WORD * (1 + extra_words);
   endfunction

endpackage

// File: rtl/status_regfile.sv
// Status register file: one synchronous write port and one
// registered read port (old data returned on a same-address collision).
module status_regfile #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [31:0]           i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [31:0]           o_rdata
);

   logic [31:0] r_mem [2**ADDR_WIDTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/status_pkt_receiver.sv
// Status channel receiver: acknowledges one source, deserializes the
// address byte plus payload words and writes them to the register file.
module status_pkt_receiver
   import status_pkt_receiver_pkg::*;
#(
   parameter int EXTRA_WORDS    = 2,
   parameter int REG_ADDR_WIDTH = 8,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [7:0]                status_ad,
   input  logic                      status_rq,
   output logic                      status_start,
   output logic                      wr_stb,
   output logic [REG_ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]               wr_data,
   output logic                      pkt_done,
   output logic                      busy,
   output logic [CNT_WIDTH-1:0]      pkt_cnt,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
   output logic [31:0]               rd_data
);

   localparam int NBYTES = status_data_bytes(EXTRA_WORDS);
   localparam int BW     = $clog2(NBYTES);

   status_state_e r_state;
   status_state_e w_state_nxt;

   logic [BW-1:0]             r_cnt;
   logic [REG_ADDR_WIDTH-1:0] r_base;
   logic [23:0]               r_word;
   logic                      r_wr_stb;
   logic [REG_ADDR_WIDTH-1:0] r_wr_addr;
   logic [31:0]               r_wr_data;
   logic                      r_pkt_done;
   logic [CNT_WIDTH-1:0]      r_pkt_cnt;

   logic                      w_start;
   logic                      w_last;
   logic                      w_word_end;
   logic [REG_ADDR_WIDTH-1:0] w_word_idx;

   assign w_last     = (r_cnt == BW'(NBYTES - 1));
   assign w_word_end = (r_cnt[1:0] == 2'd3);
   assign w_word_idx = REG_ADDR_WIDTH'(r_cnt >> 2);

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_start = enable & status_rq;
            if (w_start) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_base     <= '0;
         r_word     <= '0;
         r_wr_stb   <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_pkt_done <= 1'b0;
         r_pkt_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_stb   <= 1'b0;
         r_pkt_done <= 1'b0;
         if (w_start) begin
            r_base <= status_ad[REG_ADDR_WIDTH-1:0];
            r_cnt  <= '0;
         end
         if (r_state == ST_DATA) begin
            r_cnt <= r_cnt + BW'(1);
            // LSB byte arrives first, so shift new bytes in from the top
            if (!w_word_end) begin
               r_word <= {status_ad, r_word[23:8]};
            end else begin
               r_wr_stb  <= 1'b1;
               r_wr_addr <= r_base + w_word_idx;
               r_wr_data <= {status_ad, r_word};
               if (w_last) begin
                  r_pkt_done <= 1'b1;
                  r_pkt_cnt  <= r_pkt_cnt + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   status_regfile #(
      .ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (r_wr_stb),
      .i_waddr (r_wr_addr),
      .i_wdata (r_wr_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

   assign status_start = w_start;
   assign wr_stb       = r_wr_stb;
   assign wr_addr      = r_wr_addr;
   assign wr_data      = r_wr_data;
   assign pkt_done     = r_pkt_done;
   assign busy         = (r_state == ST_DATA);
   assign pkt_cnt      = r_pkt_cnt;

endmodule
